srv_icache_sa: RTL and testbench

- Parametrised set-associative L1 instruction cache between the schoolRISCV fetch stage and the external memory interface (MIF).
- Generalises the fully-associative L1I to NSETS x NWAYS geometry with per-set tree-PLRU replacement.
- Adds a refill FSM with a line-aligned MIF request and whole-cache invalidation for fence.i.

---
 rtl/srv_icache_sa.sv | 252 +++++++++++++++++++++++++
 tb/tb_srv_icache_sa.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srv_icache_sa.sv
// Set-associative L1 instruction cache with tree-PLRU replacement, refill FSM and fence.i invalidation.
// Optional hit/miss counters are enabled by defining SRV_ICACHE_PERF_EN.
module srv_icache_sa #(
  parameter int NSETS      = 8,
  parameter int NWAYS      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      im_req_i,
  input  logic [31:0]               im_addr_i,
  output logic [31:0]               im_data_o,
  output logic                      im_drdy_o,
  input  logic                      inv_i,
  output logic [31:0]               ext_addr_o,
  output logic                      ext_req_o,
  input  logic                      ext_rsp_i,
  input  logic [32*LINE_WORDS-1:0]  ext_data_i,
  output logic [31:0]               perf_hit_o,
  output logic [31:0]               perf_miss_o
);

  localparam int OFFS_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(NSETS);
  localparam int TAG_W  = 32 - IDX_W - OFFS_W;
  localparam int WAY_W  = $clog2(NWAYS);
  localparam int SET_W  = (IDX_W > 0) ? IDX_W : 1;
  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               req_addr_q, req_addr_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      ext_req_q, ext_req_d;
  logic [31:0]               ext_addr_q, ext_addr_d;
  logic                      inv_pend_q, inv_pend_d;

  logic [NSETS-1:0][NWAYS-1:0] valid_q;
  logic [NSETS-1:0][NWAYS-2:0] plru_q;
  logic [TAG_W-1:0]            tag_q  [NSETS][NWAYS];
  logic [32*LINE_WORDS-1:0]    line_q [NSETS][NWAYS];

  logic [SET_W-1:0]  set_idx;
  logic [WORD_W-1:0] word_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [NWAYS-1:0]  hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [31:0]       hit_word;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim;
  logic              drdy;
  logic [31:0]       rdata_out;
  logic              clear_all;
  logic              hit_upd;
  logic              fill;
  logic              unused_addr_bits;

  // Each node on the accessed way's path is set to point at the other subtree.
  function automatic logic [NWAYS-2:0] plru_touch(input logic [NWAYS-2:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NWAYS-2:0] res;
    int               n;
    res = bits;
    n   = 0;
    for (int l = 0; l < WAY_W; l++) begin
      res[n] = ~way[WAY_W-1-l];
      n      = 2 * n + 1 + (way[WAY_W-1-l] ? 1 : 0);
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NWAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    int               n;
    v = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v[WAY_W-1-l] = bits[n];
      n            = 2 * n + 1 + (bits[n] ? 1 : 0);
    end
    return v;
  endfunction

  assign unused_addr_bits = ^req_addr_q[1:0];

  always_comb begin
    set_idx   = (NSETS > 1) ? req_addr_q[OFFS_W +: SET_W] : '0;
    word_idx  = (LINE_WORDS > 1) ? req_addr_q[2 +: WORD_W] : '0;
    req_tag   = req_addr_q[31 -: TAG_W];
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag);
      if (hit_vec[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    hit_word = line_q[set_idx][hit_way][32*word_idx +: 32];
    victim   = inv_found ? inv_way : plru_victim(plru_q[set_idx]);
  end

  // Request FSM: hits answer combinationally from LOOKUP, misses go through REFILL and RESP.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = rdata_q;
    ext_req_d  = ext_req_q;
    ext_addr_d = ext_addr_q;
    inv_pend_d = inv_pend_q;
    drdy       = 1'b0;
    rdata_out  = rdata_q;
    clear_all  = 1'b0;
    hit_upd    = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        clear_all = inv_i;
        if (im_req_i) begin
          req_addr_d = im_addr_i;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (inv_i) inv_pend_d = 1'b1;
        if (hit) begin
          drdy      = 1'b1;
          rdata_out = hit_word;
          rdata_d   = hit_word;
          hit_upd   = 1'b1;
          if (inv_pend_q || inv_i) begin
            clear_all  = 1'b1;
            inv_pend_d = 1'b0;
          end
          if (im_req_i) begin
            req_addr_d = im_addr_i;
            state_d    = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ext_req_d  = 1'b1;
          ext_addr_d = {req_addr_q[31:OFFS_W], {OFFS_W{1'b0}}};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (inv_i) inv_pend_d = 1'b1;
        if (ext_rsp_i) begin
          fill      = 1'b1;
          ext_req_d = 1'b0;
          rdata_d   = ext_data_i[32*word_idx +: 32];
          state_d   = RESP;
        end
      end
      RESP: begin
        drdy = 1'b1;
        if (inv_pend_q || inv_i) begin
          clear_all  = 1'b1;
          inv_pend_d = 1'b0;
        end
        if (im_req_i) begin
          req_addr_d = im_addr_i;
          state_d    = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      rdata_q    <= '0;
      ext_req_q  <= 1'b0;
      ext_addr_q <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      ext_req_q  <= ext_req_d;
      ext_addr_q <= ext_addr_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  // Invalidation takes priority over any same-cycle PLRU or valid update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      if (hit_upd) plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
      if (fill) begin
        valid_q[set_idx][victim] <= 1'b1;
        plru_q[set_idx]          <= plru_touch(plru_q[set_idx], victim);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[set_idx][victim]  <= req_tag;
      line_q[set_idx][victim] <= ext_data_i;
    end
  end

`ifdef SRV_ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (inv_i) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) perf_hit_q  <= perf_hit_q + 32'd1;
      else     perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`else
  assign perf_hit_o  = '0;
  assign perf_miss_o = '0;
`endif

  assign im_drdy_o  = drdy;
  assign im_data_o  = rdata_out;
  assign ext_req_o  = ext_req_q;
  assign ext_addr_o = ext_addr_q;

endmodule

// File: tb/tb_srv_icache_sa.sv
// Directed-vector bench for srv_icache_sa (default geometry: 8 sets, 4 ways, 4-word lines).
module tb_srv_icache_sa;

  logic         clk;
  logic         rst_n;
  logic         im_req_i;
  logic [31:0]  im_addr_i;
  logic [31:0]  im_data_o;
  logic         im_drdy_o;
  logic         inv_i;
  logic [31:0]  ext_addr_o;
  logic         ext_req_o;
  logic         ext_rsp_i;
  logic [127:0] ext_data_i;
  logic [31:0]  perf_hit_o;
  logic [31:0]  perf_miss_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

`ifdef SRV_ICACHE_PERF_EN
  localparam logic [31:0] EXP_PHIT  = 32'd0;
  localparam logic [31:0] EXP_PMISS = 32'd1;
`else
  localparam logic [31:0] EXP_PHIT  = 32'd0;
  localparam logic [31:0] EXP_PMISS = 32'd0;
`endif

  srv_icache_sa dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_req_i    (im_req_i),
    .im_addr_i   (im_addr_i),
    .im_data_o   (im_data_o),
    .im_drdy_o   (im_drdy_o),
    .inv_i       (inv_i),
    .ext_addr_o  (ext_addr_o),
    .ext_req_o   (ext_req_o),
    .ext_rsp_i   (ext_rsp_i),
    .ext_data_i  (ext_data_i),
    .perf_hit_o  (perf_hit_o),
    .perf_miss_o (perf_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ {addr[31:2], 2'b00};
  endfunction

  function automatic logic [127:0] mk_line(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = exp_word(base + 32'(4 * w));
    return l;
  endfunction

  // Issues one fetch starting at a negedge; on a miss the MIF answers 3 cycles after ext_req_o rises.
  task automatic fetch(input logic [31:0] addr, input logic [127:0] line,
                       output logic hit, output logic [31:0] data,
                       output logic [31:0] eaddr, output int lat, output logic ereq_hit);
    int t0;
    t0        = cyc;
    lat       = 0;
    im_req_i  = 1'b1;
    im_addr_i = addr;
    @(negedge clk);
    im_req_i = 1'b0;
    hit      = im_drdy_o;
    data     = im_data_o;
    eaddr    = ext_addr_o;
    ereq_hit = ext_req_o;
    if (hit) begin
      lat = cyc - t0;
      @(negedge clk);
      ereq_hit = ereq_hit | ext_req_o;
    end else begin
      for (int i = 0; i < 10 && !ext_req_o; i++) @(negedge clk);
      if (!ext_req_o) return;
      eaddr = ext_addr_o;
      repeat (3) @(negedge clk);
      ext_data_i = line;
      ext_rsp_i  = 1'b1;
      @(negedge clk);
      ext_rsp_i = 1'b0;
      for (int i = 0; i < 10 && !im_drdy_o; i++) @(negedge clk);
      if (im_drdy_o) begin
        data = im_data_o;
        lat  = cyc - t0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    im_req_i   = 1'b0;
    im_addr_i  = '0;
    inv_i      = 1'b0;
    ext_rsp_i  = 1'b0;
    ext_data_i = '0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (im_drdy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_drdy got %b exp 0", im_drdy_o); end
    vec_cnt++; if (im_data_o !== 32'h0) begin err_cnt++; $display("[TB] FAIL reset_data got %h exp 0", im_data_o); end
    vec_cnt++; if (ext_req_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ext_req got %b exp 0", ext_req_o); end
    vec_cnt++; if (ext_addr_o !== 32'h0) begin err_cnt++; $display("[TB] FAIL reset_ext_addr got %h exp 0", ext_addr_o); end
    vec_cnt++; if ({perf_hit_o, perf_miss_o} !== 64'h0) begin err_cnt++; $display("[TB] FAIL reset_perf got %h/%h exp 0/0", perf_hit_o, perf_miss_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    logic hit, eh; logic [31:0] d, ea; int lat;
    fetch(32'h0000_0104, {32'h44, 32'h33, 32'h22, 32'h11}, hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("[TB] FAIL cold_hit got %b exp 0", hit); end
    vec_cnt++; if (ea !== 32'h0000_0100) begin err_cnt++; $display("[TB] FAIL cold_ext_addr got %h exp 00000100", ea); end
    vec_cnt++; if (d !== 32'h22) begin err_cnt++; $display("[TB] FAIL cold_data got %h exp 00000022", d); end
    vec_cnt++; if (lat != 6) begin err_cnt++; $display("[TB] FAIL cold_latency got %0d exp 6", lat); end
  endtask

  task automatic test_hit_after_refill();
    logic hit, eh; logic [31:0] d, ea; int lat;
    fetch(32'h0000_010C, '0, hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b1) begin err_cnt++; $display("[TB] FAIL hit_flag got %b exp 1", hit); end
    vec_cnt++; if (d !== 32'h44) begin err_cnt++; $display("[TB] FAIL hit_data got %h exp 00000044", d); end
    vec_cnt++; if (lat != 1) begin err_cnt++; $display("[TB] FAIL hit_latency got %0d exp 1", lat); end
    vec_cnt++; if (eh !== 1'b0) begin err_cnt++; $display("[TB] FAIL hit_ext_req got %b exp 0", eh); end
  endtask

  task automatic test_plru_eviction();
    logic hit, eh; logic [31:0] d, ea; int lat;
    fetch(32'h0000_0000, mk_line(32'h000), hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("[TB] FAIL fill_000 hit got %b exp 0", hit); end
    fetch(32'h0000_0080, mk_line(32'h080), hit, d, ea, lat, eh);
    vec_cnt++; if (d !== exp_word(32'h080)) begin err_cnt++; $display("[TB] FAIL fill_080 data got %h exp %h", d, exp_word(32'h080)); end
    fetch(32'h0000_0100, '0, hit, d, ea, lat, eh);
    vec_cnt++; if ({hit, d} !== {1'b1, 32'h11}) begin err_cnt++; $display("[TB] FAIL hit_100 got %b/%h exp 1/00000011", hit, d); end
    fetch(32'h0000_0180, mk_line(32'h180), hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("[TB] FAIL fill_180 hit got %b exp 0", hit); end
    fetch(32'h0000_0000, '0, hit, d, ea, lat, eh);
    vec_cnt++; if ({hit, d} !== {1'b1, exp_word(32'h000)}) begin err_cnt++; $display("[TB] FAIL touch_000 got %b/%h exp 1/%h", hit, d, exp_word(32'h000)); end
    fetch(32'h0000_0200, mk_line(32'h200), hit, d, ea, lat, eh);
    vec_cnt++; if ({hit, ea} !== {1'b0, 32'h200}) begin err_cnt++; $display("[TB] FAIL fill_200 got %b/%h exp 0/00000200", hit, ea); end
    fetch(32'h0000_0000, '0, hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b1) begin err_cnt++; $display("[TB] FAIL rehit_000 got %b exp 1", hit); end
    fetch(32'h0000_0088, mk_line(32'h080), hit, d, ea, lat, eh);
    vec_cnt++; if ({hit, ea} !== {1'b0, 32'h080}) begin err_cnt++; $display("[TB] FAIL evicted_080 got %b/%h exp 0/00000080", hit, ea); end
    vec_cnt++; if (d !== exp_word(32'h088)) begin err_cnt++; $display("[TB] FAIL evicted_080 data got %h exp %h", d, exp_word(32'h088)); end
  endtask

  task automatic test_invalidate();
    logic hit, eh; logic [31:0] d, ea; int lat;
    inv_i = 1'b1;
    @(negedge clk);
    inv_i = 1'b0;
    fetch(32'h0000_0104, {32'h44, 32'h33, 32'h22, 32'h11}, hit, d, ea, lat, eh);
    vec_cnt++; if ({hit, ea} !== {1'b0, 32'h100}) begin err_cnt++; $display("[TB] FAIL inv_miss got %b/%h exp 0/00000100", hit, ea); end
    vec_cnt++; if (d !== 32'h22) begin err_cnt++; $display("[TB] FAIL inv_data got %h exp 00000022", d); end
    vec_cnt++; if (perf_hit_o !== EXP_PHIT) begin err_cnt++; $display("[TB] FAIL inv_perf_hit got %0d exp %0d", perf_hit_o, EXP_PHIT); end
    vec_cnt++; if (perf_miss_o !== EXP_PMISS) begin err_cnt++; $display("[TB] FAIL inv_perf_miss got %0d exp %0d", perf_miss_o, EXP_PMISS); end
  endtask

  task automatic test_inv_during_refill();
    logic hit, eh, seen; logic [31:0] d, ea; int lat;
    im_req_i  = 1'b1;
    im_addr_i = 32'h0000_0304;
    @(negedge clk);
    im_req_i = 1'b0;
    for (int i = 0; i < 10 && !ext_req_o; i++) @(negedge clk);
    inv_i = 1'b1;
    @(negedge clk);
    inv_i = 1'b0;
    repeat (2) @(negedge clk);
    ext_data_i = mk_line(32'h300);
    ext_rsp_i  = 1'b1;
    @(negedge clk);
    ext_rsp_i = 1'b0;
    for (int i = 0; i < 10 && !im_drdy_o; i++) @(negedge clk);
    seen = im_drdy_o;
    d    = im_data_o;
    @(negedge clk);
    vec_cnt++; if (seen !== 1'b1) begin err_cnt++; $display("[TB] FAIL invref_drdy got %b exp 1", seen); end
    vec_cnt++; if (d !== exp_word(32'h304)) begin err_cnt++; $display("[TB] FAIL invref_data got %h exp %h", d, exp_word(32'h304)); end
    fetch(32'h0000_0304, mk_line(32'h300), hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("[TB] FAIL invref_rereq hit got %b exp 0", hit); end
  endtask

  task automatic test_reset_in_refill();
    logic hit, eh, any_drdy; logic [31:0] d, ea; int lat;
    im_req_i  = 1'b1;
    im_addr_i = 32'h0000_0404;
    @(negedge clk);
    im_req_i = 1'b0;
    for (int i = 0; i < 10 && !ext_req_o; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (ext_req_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_ext_req got %b exp 0", ext_req_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ext_data_i = mk_line(32'h400);
    ext_rsp_i  = 1'b1;
    any_drdy   = 1'b0;
    @(negedge clk);
    ext_rsp_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_drdy = any_drdy | im_drdy_o;
      @(negedge clk);
    end
    vec_cnt++; if (any_drdy !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_late_rsp drdy got %b exp 0", any_drdy); end
    fetch(32'h0000_0404, mk_line(32'h400), hit, d, ea, lat, eh);
    vec_cnt++; if (hit !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_no_write hit got %b exp 0", hit); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2; logic r1, r2;
    im_req_i  = 1'b1;
    im_addr_i = 32'h0000_0404;
    @(negedge clk);
    r1        = im_drdy_o;
    d1        = im_data_o;
    im_addr_i = 32'h0000_0408;
    @(negedge clk);
    im_req_i = 1'b0;
    r2       = im_drdy_o;
    d2       = im_data_o;
    @(negedge clk);
    vec_cnt++; if ({r1, d1} !== {1'b1, exp_word(32'h404)}) begin err_cnt++; $display("[TB] FAIL b2b_first got %b/%h exp 1/%h", r1, d1, exp_word(32'h404)); end
    vec_cnt++; if ({r2, d2} !== {1'b1, exp_word(32'h408)}) begin err_cnt++; $display("[TB] FAIL b2b_second got %b/%h exp 1/%h", r2, d2, exp_word(32'h408)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_refill();
    test_plru_eviction();
    test_invalidate();
    test_inv_during_refill();
    test_reset_in_refill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
